mux_rr_arb: RTL and testbench
=============================

# mux_rr_arb

Two-channel round-robin arbiter that sits directly upstream of the `mux2to1` stage. It accepts data from channel A and channel B over valid/ready handshakes and decides the select for each cycle. It routes the winning word through a `mux2to1` instance on a `mux_if`, then buffers the result in a 2-entry output FIFO with its own valid/ready handshake. It replaces free-running `i_sel` driving with fair, back-pressured selection.

## Interface
- `DATA_WITH`, 12, width of each data word on A, B and Y.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset; asynchronous, active-low.
- `i_a`  in  DATA_WITH  channel A data.
- `i_a_valid`  in  1  channel A word present.
- `o_a_ready`  out  1  channel A word is taken this cycle when `i_a_valid` is also high.
- `i_b`  in  DATA_WITH  channel B data.
- `i_b_valid`  in  1  channel B word present.
- `o_b_ready`  out  1  channel B word is taken this cycle when `i_b_valid` is also high.
- `o_y`  out  DATA_WITH  head-of-FIFO data.
- `o_y_valid`  out  1  FIFO not empty.
- `i_y_ready`  in  1  downstream pops the head when `o_y_valid` is high.
- `o_y_src`  out  1  source of the head word: 0 = A, 1 = B.

## Operation
- Priority FSM has two states.
  - PRI_A: A wins a tie.
  - PRI_B: B wins a tie.
  - Reset state is PRI_A.
- Grant is combinational and only possible when the FIFO is not full (count < 2).
  - Exactly one valid: that channel wins.
  - Both valid: the priority channel wins.
  - Neither valid: no grant.
- `o_a_ready` = grant to A; `o_b_ready` = grant to B. At most one is high per cycle. Both are low when the FIFO is full, regardless of `i_y_ready`.
- Priority update happens on every accepted transfer.
  - After a grant to A, the next state is PRI_B.
  - After a grant to B, the next state is PRI_A.
  - With no grant, the state holds.
- Mux path:
  - Drive `mux_if.a` = `i_a`, `mux_if.b` = `i_b`, `mux_if.sel` = grant-to-B.
  - The `mux2to1` output `y` is the push data.
  - `o_y_src` is pushed alongside each word.
- FIFO: 2 entries, 1-bit read/write pointers, 2-bit count (0..2).
  - Push on grant; pop on `o_y_valid & i_y_ready`.
  - Simultaneous push and pop (count 1) leaves count unchanged. Pointers wrap modulo 2.
  - Push when full cannot happen, because grant is gated by full.
  - Pop when empty is ignored.
- Reset values:
  - FIFO: count 0.
  - Pointers: 0.
  - `o_y_valid`: 0.
  - `o_y`: 0.
  - `o_y_src`: 0.
  - `o_a_ready`: 0.
  - `o_b_ready`: 0.
  - FSM: PRI_A.
- Reset asserted mid-operation discards all buffered words immediately. No handshake completes in that cycle.

## Timing
- Latency: a word accepted in cycle N is on `o_y` with `o_y_valid` = 1 in cycle N+1 if the FIFO was empty. Otherwise it appears behind the older entries.
- Throughput: one word per cycle sustained while `i_y_ready` = 1.
- No combinational path from `i_y_ready` to `o_a_ready`/`o_b_ready`; the ready outputs depend only on registered count and current input valids.
- `o_y`, `o_y_src` and `o_y_valid` come from registered FIFO storage. There is no combinational path from any input to them.
- With `i_y_ready` held low, a maximum of 2 words are accepted before both readies drop.

## Structure
- Package `mux_pkg` holds:
  - `typedef enum logic {PRI_A, PRI_B} pri_e`.
  - Constant `FIFO_DEPTH = 2`.
  - Source encodings `SRC_A = 1'b0`, `SRC_B = 1'b1`.
- Sub-module: `mux2to1` (the existing block), instantiated once through a `mux_if #(.DATA_WITH(DATA_WITH))`.
- FIFO storage and the FSM are inline in `mux_rr_arb`.

## Test plan
- Reset check: hold `i_rst_n` = 0 with both valids high.
  - Required: both readies 0, `o_y_valid` 0, `o_y` 0.
  - Release reset: first grant goes to A.
- Alternation: both valid every cycle, A = 0x111, B = 0x222, `i_y_ready` = 1.
  - Required output sequence: 0x111/src 0, 0x222/src 1, 0x111, 0x222.
  - Each word appears one cycle after its acceptance.
- Single requester: only B valid for 4 cycles with data 0x00A, 0x00B, 0x00C, 0x00D.
  - Required: all 4 granted back-to-back.
  - Then set both valid: A wins, since the FSM is in PRI_A after a B grant.
- Back-pressure/full: `i_y_ready` = 0 and A valid with 0x5A5.
  - Required: 2 words accepted, then `o_a_ready` = 0.
  - Raise `i_y_ready`: pops resume in order, and readiness returns the cycle after count drops below 2.
- Simultaneous push/pop at count 1: A pushes 0xABC while the head pops.
  - Required: count stays 1 and the next head is 0xABC.
- Reset mid-stream: assert `i_rst_n` low with 2 words buffered.
  - Required: `o_y_valid` goes low asynchronously.
  - After release, no stale words appear and the priority is PRI_A.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and constants for the two-channel round-robin arbiter.
package mux_pkg;
  typedef enum logic {PRI_A, PRI_B} pri_e;

  localparam int   FIFO_DEPTH = 2;
  localparam logic SRC_A      = 1'b0;
  localparam logic SRC_B      = 1'b1;
endpackage

// File: rtl/mux_if.sv
// Bundle between the arbiter and its 2:1 data mux.
interface mux_if #(
  parameter int DATA_WITH = 12
);
  logic [DATA_WITH-1:0] a;
  logic [DATA_WITH-1:0] b;
  logic [DATA_WITH-1:0] y;
  logic                 sel;

  modport mux (input a, input b, input sel, output y);
  modport drv (output a, output b, output sel, input y);
endinterface

// File: rtl/mux2to1.sv
// Combinational 2:1 word mux; zero latency, no flow control (sel=1 picks b).
module mux2to1 (
  mux_if.mux bus
);
  assign bus.y = bus.sel ? bus.b : bus.a;
endmodule

// File: rtl/mux_rr_arb.sv
// Round-robin A/B arbiter feeding a 2-entry output FIFO; accepted word visible next cycle.
// Readies drop only when the FIFO holds 2 words; i_y_ready never reaches the readies combinationally.
module mux_rr_arb
  import mux_pkg::*;
#(
  parameter int DATA_WITH = 12
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DATA_WITH-1:0] i_a,
  input  logic                 i_a_valid,
  output logic                 o_a_ready,
  input  logic [DATA_WITH-1:0] i_b,
  input  logic                 i_b_valid,
  output logic                 o_b_ready,
  output logic [DATA_WITH-1:0] o_y,
  output logic                 o_y_valid,
  input  logic                 i_y_ready,
  output logic                 o_y_src
);

  pri_e                 pri_q, pri_d;
  logic [1:0]           count_q, count_d;
  logic                 wr_ptr_q, wr_ptr_d;
  logic                 rd_ptr_q, rd_ptr_d;
  logic [DATA_WITH-1:0] mem_dat_q [FIFO_DEPTH];
  logic                 mem_src_q [FIFO_DEPTH];

  logic full, gnt_a, gnt_b, push, pop;

  mux_if #(.DATA_WITH(DATA_WITH)) mux_bus ();

  assign mux_bus.a   = i_a;
  assign mux_bus.b   = i_b;
  assign mux_bus.sel = gnt_b;

  mux2to1 u_mux (.bus(mux_bus));

  assign full = (count_q == 2'(FIFO_DEPTH));

  // Grant is held off while reset is asserted so no handshake completes in a reset cycle.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (i_rst_n && !full) begin
      if (i_a_valid && (!i_b_valid || pri_q == PRI_A)) begin
        gnt_a = 1'b1;
      end else if (i_b_valid) begin
        gnt_b = 1'b1;
      end
    end
  end

  always_comb begin
    pri_d = pri_q;
    if (gnt_a) begin
      pri_d = PRI_B;
    end else if (gnt_b) begin
      pri_d = PRI_A;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pri_q <= PRI_A;
    end else begin
      pri_q <= pri_d;
    end
  end

  assign push      = gnt_a | gnt_b;
  assign o_y_valid = (count_q != 2'd0);
  assign pop       = o_y_valid & i_y_ready;
  assign o_a_ready = gnt_a;
  assign o_b_ready = gnt_b;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_dat_q[i] <= '0;
        mem_src_q[i] <= SRC_A;
      end
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (push) begin
        mem_dat_q[wr_ptr_q] <= mux_bus.y;
        mem_src_q[wr_ptr_q] <= gnt_b ? SRC_B : SRC_A;
      end
    end
  end

  assign o_y     = mem_dat_q[rd_ptr_q];
  assign o_y_src = mem_src_q[rd_ptr_q];

endmodule

// File: tb/tb_mux_rr_arb.sv
// Bench for mux_rr_arb: hand-derived vector table, reset sequences, and random traffic against a queue model.
module tb_mux_rr_arb;
  localparam int W = 12;

  logic         i_clk = 1'b0;
  logic         i_rst_n;
  logic [W-1:0] i_a, i_b, o_y;
  logic         i_a_valid, i_b_valid, o_a_ready, o_b_ready;
  logic         o_y_valid, i_y_ready, o_y_src;

  mux_rr_arb #(.DATA_WITH(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_a(i_a), .i_a_valid(i_a_valid), .o_a_ready(o_a_ready),
    .i_b(i_b), .i_b_valid(i_b_valid), .o_b_ready(o_b_ready),
    .o_y(o_y), .o_y_valid(o_y_valid), .i_y_ready(i_y_ready), .o_y_src(o_y_src)
  );

  initial forever #5 i_clk = ~i_clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: FIFO contents as a queue, plus who won the last grant.
  typedef struct {
    logic [W-1:0] d;
    logic         s;
  } ent_t;
  ent_t q[$];
  logic last_b = 1'b1;

  logic         s_ar, s_br, s_yv, s_src;
  logic [W-1:0] s_y;

  typedef struct {
    logic [W-1:0] a;
    logic         av;
    logic [W-1:0] b;
    logic         bv;
    logic         yr;
    logic         ar;
    logic         br;
    logic         yv;
    logic [W-1:0] y;
    logic         src;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input logic [W-1:0] a, input logic av, input logic [W-1:0] b,
                     input logic bv, input logic yr);
    logic ga, gb;
    ent_t e;
    i_a = a; i_a_valid = av; i_b = b; i_b_valid = bv; i_y_ready = yr;
    @(negedge i_clk);
    ga = 1'b0; gb = 1'b0;
    if (q.size() < 2) begin
      if (av && bv) begin
        if (last_b) ga = 1'b1; else gb = 1'b1;
      end else if (av) begin
        ga = 1'b1;
      end else if (bv) begin
        gb = 1'b1;
      end
    end
    s_ar = o_a_ready; s_br = o_b_ready; s_yv = o_y_valid; s_y = o_y; s_src = o_y_src;
    chk("a_ready", 32'(s_ar), 32'(ga));
    chk("b_ready", 32'(s_br), 32'(gb));
    chk("y_valid", 32'(s_yv), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("y_data", 32'(s_y), 32'(q[0].d));
      chk("y_src", 32'(s_src), 32'(q[0].s));
    end
    @(posedge i_clk);
    if (q.size() != 0 && yr) void'(q.pop_front());
    if (ga) begin
      e.d = a; e.s = 1'b0; q.push_back(e); last_b = 1'b0;
    end else if (gb) begin
      e.d = b; e.s = 1'b1; q.push_back(e); last_b = 1'b1;
    end
    #1;
  endtask

  initial begin
    // a, av, b, bv, yr | ar, br, yv, y, src
    tbl[0]  = '{12'h111, 1, 12'h222, 1, 1, 1, 0, 0, 12'h000, 0};
    tbl[1]  = '{12'h111, 1, 12'h222, 1, 1, 0, 1, 1, 12'h111, 0};
    tbl[2]  = '{12'h111, 1, 12'h222, 1, 1, 1, 0, 1, 12'h222, 1};
    tbl[3]  = '{12'h111, 1, 12'h222, 1, 1, 0, 1, 1, 12'h111, 0};
    tbl[4]  = '{12'h000, 0, 12'h00A, 1, 1, 0, 1, 1, 12'h222, 1};
    tbl[5]  = '{12'h000, 0, 12'h00B, 1, 1, 0, 1, 1, 12'h00A, 1};
    tbl[6]  = '{12'h000, 0, 12'h00C, 1, 1, 0, 1, 1, 12'h00B, 1};
    tbl[7]  = '{12'h000, 0, 12'h00D, 1, 1, 0, 1, 1, 12'h00C, 1};
    tbl[8]  = '{12'h333, 1, 12'h444, 1, 1, 1, 0, 1, 12'h00D, 1};
    tbl[9]  = '{12'h5A5, 1, 12'h000, 0, 0, 1, 0, 1, 12'h333, 0};
    tbl[10] = '{12'h5A5, 1, 12'h000, 0, 0, 0, 0, 1, 12'h333, 0};
    tbl[11] = '{12'h5A5, 1, 12'h000, 0, 1, 0, 0, 1, 12'h333, 0};
    tbl[12] = '{12'hABC, 1, 12'h000, 0, 1, 1, 0, 1, 12'h5A5, 0};
    tbl[13] = '{12'h000, 0, 12'h000, 0, 1, 0, 0, 1, 12'hABC, 0};
    tbl[14] = '{12'h000, 0, 12'h000, 0, 1, 0, 0, 0, 12'h000, 0};

    i_rst_n = 1'b0;
    i_a = 12'h123; i_b = 12'h456; i_a_valid = 1'b1; i_b_valid = 1'b1; i_y_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_a_ready", 32'(o_a_ready), 32'd0);
    chk("rst_b_ready", 32'(o_b_ready), 32'd0);
    chk("rst_y_valid", 32'(o_y_valid), 32'd0);
    chk("rst_y", 32'(o_y), 32'd0);
    chk("rst_y_src", 32'(o_y_src), 32'd0);
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      cyc(tbl[i].a, tbl[i].av, tbl[i].b, tbl[i].bv, tbl[i].yr);
      chk($sformatf("tbl%0d_a_ready", i), 32'(s_ar), 32'(tbl[i].ar));
      chk($sformatf("tbl%0d_b_ready", i), 32'(s_br), 32'(tbl[i].br));
      chk($sformatf("tbl%0d_y_valid", i), 32'(s_yv), 32'(tbl[i].yv));
      if (tbl[i].yv) begin
        chk($sformatf("tbl%0d_y", i), 32'(s_y), 32'(tbl[i].y));
        chk($sformatf("tbl%0d_src", i), 32'(s_src), 32'(tbl[i].src));
      end
    end

    for (int i = 0; i < 400; i++) begin
      cyc(W'($urandom), 1'($urandom), W'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    // Mid-stream reset with the FIFO full.
    repeat (3) cyc(12'h000, 1'b0, 12'h000, 1'b0, 1'b1);
    cyc(12'h777, 1'b1, 12'h888, 1'b1, 1'b0);
    cyc(12'h777, 1'b1, 12'h888, 1'b1, 1'b0);
    @(negedge i_clk);
    chk("full_a_ready", 32'(o_a_ready), 32'd0);
    chk("full_y_valid", 32'(o_y_valid), 32'd1);
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrst_y_valid", 32'(o_y_valid), 32'd0);
    chk("midrst_a_ready", 32'(o_a_ready), 32'd0);
    chk("midrst_b_ready", 32'(o_b_ready), 32'd0);
    q.delete();
    last_b = 1'b1;
    @(posedge i_clk);
    #1 i_rst_n = 1'b1;
    cyc(12'h999, 1'b1, 12'hAAA, 1'b1, 1'b1);
    chk("post_rst_a_wins", 32'(s_ar), 32'd1);
    chk("post_rst_empty", 32'(s_yv), 32'd0);
    cyc(12'h000, 1'b0, 12'h000, 1'b0, 1'b1);
    chk("post_rst_head", 32'(s_y), 32'h999);
    cyc(12'h000, 1'b0, 12'h000, 1'b0, 1'b1);
    chk("post_rst_drained", 32'(s_yv), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
